// File: rtl/ov7670_config_seq.sv
// OV7670 register-configuration sequencer: walks the config ROM from address 0 and issues one SCCB
// write per entry, honouring the delay (FFF0) and end-of-table (FFFF) sentinels with NACK retry.
module ov7670_config_seq #(
   parameter int unsigned CLK_HZ    = 25_000_000,
   parameter int unsigned DELAY_MS  = 10,
   parameter int unsigned MAX_RETRY = 3,
   parameter logic [7:0]  DEV_ID    = 8'h42
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_dout,
   input  logic        sccb_ready,
   output logic        sccb_start,
   output logic [7:0]  sccb_id,
   output logic [7:0]  sccb_reg,
   output logic [7:0]  sccb_val,
   input  logic        sccb_done,
   input  logic        sccb_nack,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  fail_addr
);

   localparam int unsigned DELAY_CYCLES = CLK_HZ / 1000 * DELAY_MS;
   localparam int unsigned DELAY_LOAD   = (DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 0;
   localparam int unsigned RETRY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

   localparam logic [15:0] ROM_END   = 16'hFFFF;
   localparam logic [15:0] ROM_DELAY = 16'hFFF0;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StIssue,
      StWait,
      StDelay,
      StDone,
      StError
   } state_e;

   state_e             state;
   logic [RETRY_W-1:0] retry;
   logic [31:0]        delay_cnt;

   assign sccb_id = DEV_ID;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         rom_addr   <= 8'd0;
         sccb_start <= 1'b0;
         sccb_reg   <= 8'd0;
         sccb_val   <= 8'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         fail_addr  <= 8'd0;
         retry      <= '0;
         delay_cnt  <= 32'd0;
      end else begin
         sccb_start <= 1'b0;
         case (state)
            StIdle, StDone, StError: begin
               if (start) begin
                  state     <= StFetch;
                  rom_addr  <= 8'd0;
                  retry     <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  fail_addr <= 8'd0;
               end
            end
            StFetch: state <= StDecode;
            StDecode: begin
               if (rom_dout == ROM_END) begin
                  state <= StDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (rom_dout == ROM_DELAY) begin
                  delay_cnt <= 32'(DELAY_LOAD);
                  state     <= StDelay;
               end else begin
                  sccb_reg <= rom_dout[15:8];
                  sccb_val <= rom_dout[7:0];
                  state    <= StIssue;
               end
            end
            StIssue: begin
               if (sccb_ready) begin
                  sccb_start <= 1'b1;
                  state      <= StWait;
               end
            end
            StWait: begin
               if (sccb_done) begin
                  if (!sccb_nack) begin
                     retry <= '0;
                     // Address FF is the last ROM slot: finish instead of wrapping to 0.
                     if (rom_addr == 8'hFF) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        rom_addr <= rom_addr + 8'd1;
                        state    <= StFetch;
                     end
                  end else if (retry < RETRY_LIMIT) begin
                     retry <= retry + 1'b1;
                     state <= StIssue;
                  end else begin
                     fail_addr <= rom_addr;
                     busy      <= 1'b0;
                     error     <= 1'b1;
                     state     <= StError;
                  end
               end
            end
            StDelay: begin
               if (delay_cnt == 32'd0) begin
                  if (rom_addr == 8'hFF) begin
                     state <= StDone;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     rom_addr <= rom_addr + 8'd1;
                     state    <= StFetch;
                  end
               end else begin
                  delay_cnt <= delay_cnt - 32'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Self-checking bench for ov7670_config_seq: ROM and SCCB master models, table-driven scenarios,
// hand-written corner cases and randomized tables checked against a table-walking reference model.
module tb_ov7670_config_seq;

   localparam int unsigned MAX_RETRY = 3;
   localparam int          DELAY_CYC = 1000;
   localparam int          ACK_LAT   = 20;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  rom_addr;
   logic [15:0] rom_dout;
   logic        sccb_ready;
   logic        sccb_start;
   logic [7:0]  sccb_id;
   logic [7:0]  sccb_reg;
   logic [7:0]  sccb_val;
   logic        sccb_done;
   logic        sccb_nack;
   logic        busy;
   logic        done;
   logic        error;
   logic [7:0]  fail_addr;

   ov7670_config_seq #(
      .CLK_HZ   (1_000_000),
      .DELAY_MS (1),
      .MAX_RETRY(MAX_RETRY),
      .DEV_ID   (8'h42)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rom_addr  (rom_addr),
      .rom_dout  (rom_dout),
      .sccb_ready(sccb_ready),
      .sccb_start(sccb_start),
      .sccb_id   (sccb_id),
      .sccb_reg  (sccb_reg),
      .sccb_val  (sccb_val),
      .sccb_done (sccb_done),
      .sccb_nack (sccb_nack),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .fail_addr (fail_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered ROM model
   logic [15:0] rom [256];
   initial rom_dout = 16'd0;
   always @(posedge clk) rom_dout <= rom[rom_addr];

   int          checks = 0;
   int          failures = 0;
   int          nk_init [256];
   int          nk_left [256];
   logic [23:0] log_q [$];
   logic [23:0] exp_q [$];
   bit          exp_done;
   bit          exp_err;
   logic [7:0]  exp_fail;
   int          start_cnt = 0;
   int          width_err = 0;
   int          proto_err = 0;
   int          addr1_cycles = 0;
   bit          stall = 0;

   typedef struct packed {
      logic [7:0][15:0] e;   // entry 7 is leftmost in the literal
      logic [7:0][2:0]  nk;  // NACKs before ACK per entry
      logic [8:0]       starts;
      logic             exp_d;
      logic             exp_e;
      logic [7:0]       fail;
   } vec_t;

   // SCCB master model: ACKs ACK_LAT cycles after a command, NACKing per nk_left budget.
   initial begin : sccb_master
      int  m_cnt;
      bit  m_busy;
      bit  prev_start;
      logic rp;
      sccb_ready = 1'b1;
      sccb_done  = 1'b0;
      sccb_nack  = 1'b0;
      m_busy     = 0;
      m_cnt      = 0;
      prev_start = 0;
      forever begin
         @(negedge clk);
         rp        = sccb_ready;
         sccb_done = 1'b0;
         sccb_nack = 1'b0;
         if (!rst_n) begin
            m_busy     = 0;
            prev_start = 0;
         end else begin
            if (sccb_start && prev_start) width_err++;
            if (sccb_start && !rp) proto_err++;
            prev_start = sccb_start;
            if (sccb_start) begin
               log_q.push_back({rom_addr, sccb_reg, sccb_val});
               start_cnt++;
               m_busy = 1;
               m_cnt  = ACK_LAT;
            end else if (m_busy) begin
               m_cnt--;
               if (m_cnt == 0) begin
                  m_busy    = 0;
                  sccb_done = 1'b1;
                  if (nk_left[rom_addr] > 0) begin
                     nk_left[rom_addr]--;
                     sccb_nack = 1'b1;
                  end
               end
            end
         end
         sccb_ready = rst_n && !m_busy && !stall;
         if (busy && rom_addr == 8'd1) addr1_cycles++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: walk the table by its rules and list every write attempt plus the outcome.
   task automatic build_expect();
      int a;
      int tries;
      a = 0;
      exp_q.delete();
      exp_done = 0;
      exp_err  = 0;
      exp_fail = 8'd0;
      forever begin
         if (rom[a] == 16'hFFFF) begin
            exp_done = 1;
            break;
         end
         if (rom[a] != 16'hFFF0) begin
            tries = (nk_init[a] > int'(MAX_RETRY)) ? int'(MAX_RETRY) + 1 : nk_init[a] + 1;
            for (int k = 0; k < tries; k++) exp_q.push_back({a[7:0], rom[a]});
            if (nk_init[a] > int'(MAX_RETRY)) begin
               exp_err  = 1;
               exp_fail = a[7:0];
               break;
            end
         end
         if (a == 255) begin
            exp_done = 1;
            break;
         end
         a++;
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) begin
         rom[i]     = 16'hFFFF;
         nk_init[i] = 0;
      end
   endtask

   task automatic load_vec(input vec_t v);
      clear_rom();
      for (int i = 0; i < 8; i++) begin
         rom[i]     = v.e[i];
         nk_init[i] = int'(v.nk[i]);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input int stall_cyc, input bit poke);
      int cyc;
      build_expect();
      log_q.delete();
      start_cnt    = 0;
      addr1_cycles = 0;
      for (int i = 0; i < 256; i++) nk_left[i] = nk_init[i];
      if (stall_cyc > 0) stall = 1;
      pulse_start();
      chk({tag, " busy after start"}, 32'(busy), 32'd1);
      chk({tag, " error cleared"}, {error, fail_addr}, 32'd0);
      if (stall_cyc > 0) begin
         repeat (stall_cyc) @(negedge clk);
         chk({tag, " no start while stalled"}, start_cnt, 32'd0);
         stall = 0;
      end
      cyc = 0;
      while (!(done || error) && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         start = poke && cyc < 300 && (cyc % 17 == 5);
      end
      start = 1'b0;
      chk({tag, " finished in budget"}, 32'(cyc < 30000), 32'd1);
      chk({tag, " done"}, 32'(done), 32'(exp_done));
      chk({tag, " error"}, 32'(error), 32'(exp_err));
      chk({tag, " busy low"}, 32'(busy), 32'd0);
      chk({tag, " fail_addr"}, 32'(fail_addr), 32'(exp_fail));
      chk({tag, " write count"}, log_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         chk({tag, " write"}, (k < log_q.size()) ? 32'(log_q[k]) : 32'hDEAD_BEEF, 32'(exp_q[k]));
      chk({tag, " start width/ready"}, width_err + proto_err, 32'd0);
   endtask

   vec_t vecs [6];

   initial begin : main
      int len;
      bit used_delay;
      vecs[0] = '{e: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1204, 16'hFFF0, 16'h1280},
                  nk: '0, starts: 9'd2, exp_d: 1'b1, exp_e: 1'b0, fail: 8'd0};
      vecs[1] = '{e: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1301, 16'h1180},
                  nk: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2},
                  starts: 9'd4, exp_d: 1'b1, exp_e: 1'b0, fail: 8'd0};
      vecs[2] = '{e: {16'hFFFF, 16'hFFFF, 16'h0606, 16'h0505, 16'h0404, 16'h0303, 16'h0202, 16'h0101},
                  nk: {3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                  starts: 9'd9, exp_d: 1'b0, exp_e: 1'b1, fail: 8'd5};
      vecs[3] = '{e: {8{16'hFFFF}}, nk: '0, starts: 9'd0, exp_d: 1'b1, exp_e: 1'b0, fail: 8'd0};
      vecs[4] = '{e: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h2A55},
                  nk: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4},
                  starts: 9'd4, exp_d: 1'b0, exp_e: 1'b1, fail: 8'd0};
      vecs[5] = '{e: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h2A55},
                  nk: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3},
                  starts: 9'd4, exp_d: 1'b1, exp_e: 1'b0, fail: 8'd0};

      rst_n = 1'b0;
      start = 1'b0;
      clear_rom();
      repeat (3) @(negedge clk);
      chk("reset outputs", {rom_addr, sccb_reg, sccb_val, fail_addr}, 32'd0);
      chk("reset flags", {sccb_start, busy, done, error}, 32'd0);
      chk("reset sccb_id", 32'(sccb_id), 32'h42);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int r = 0; r < 6; r++) begin
         load_vec(vecs[r]);
         run_and_check($sformatf("vec%0d", r), 0, 0);
         chk($sformatf("vec%0d starts", r), start_cnt, 32'(vecs[r].starts));
         chk($sformatf("vec%0d done/err", r), {done, error}, {vecs[r].exp_d, vecs[r].exp_e});
         chk($sformatf("vec%0d fail", r), 32'(fail_addr), 32'(vecs[r].fail));
         if (r == 0) chk("delay entry cycles", addr1_cycles, 32'(DELAY_CYC + 2));
      end

      // Abort holds with no further commands; a new start runs the table again from 0
      load_vec(vecs[2]);
      run_and_check("abort", 0, 0);
      repeat (60) @(negedge clk);
      chk("no start after abort", start_cnt, 32'd9);
      chk("error holds", {error, fail_addr}, {24'd0, 1'b1, 8'd5} >> 0);
      nk_init[5] = 0;
      run_and_check("restart", 0, 0);

      // Ready stall
      clear_rom();
      rom[0] = 16'h1280;
      run_and_check("stall", 50, 0);

      // Start pulses while busy are ignored
      clear_rom();
      rom[0] = 16'h1280;
      rom[1] = 16'h1301;
      rom[2] = 16'h1402;
      run_and_check("start ignored", 0, 1);

      // Reset mid-transaction
      clear_rom();
      rom[0] = 16'h1280;
      log_q.delete();
      start_cnt = 0;
      pulse_start();
      for (int c = 0; c < 100 && start_cnt == 0; c++) @(negedge clk);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset regs", {rom_addr, sccb_reg, sccb_val, fail_addr}, 32'd0);
      chk("async reset flags", {sccb_start, busy, done, error}, 32'd0);
      chk("async reset id", 32'(sccb_id), 32'h42);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("idle after reset", {busy, done, error, rom_addr}, 32'd0);
      chk("no activity after reset", start_cnt, 32'd1);

      // Full table without terminator: finish at FF instead of wrapping
      clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = {8'h10, 8'(i)};
      run_and_check("wrap", 0, 0);
      chk("wrap rom_addr", 32'(rom_addr), 32'hFF);

      // Randomized tables
      for (int t = 0; t < 15; t++) begin
         clear_rom();
         len = $urandom_range(1, 6);
         used_delay = 0;
         for (int j = 0; j < len; j++) begin
            if (!used_delay && $urandom_range(0, 7) == 0) begin
               rom[j] = 16'hFFF0;
               used_delay = 1;
            end else begin
               rom[j] = {8'($urandom_range(0, 254)), 8'($urandom)};
               nk_init[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            end
         end
         run_and_check($sformatf("rand%0d", t), 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ov7670_config_seq.md
Name: ov7670_config_seq

Overview:
- Sequencer that walks the OV7670 register-configuration ROM from address 0 and issues one SCCB register write per entry to the SCCB master.
- Interprets two ROM sentinels:
  - 16'hFFF0: timed delay.
  - 16'hFFFF: end of table.
- Retries NACKed writes and reports completion or failure to the top level, which holds the camera capture path until done.

Parameters:
- CLK_HZ, 25_000_000, system clock frequency in Hz.
- DELAY_MS, 10, duration of an FFF0 delay entry in milliseconds.
- MAX_RETRY, 3, maximum re-issues of a NACKed write before aborting.
- DEV_ID, 8'h42, SCCB write address of the OV7670.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins (or restarts) the sequence when in IDLE, DONE or ERROR.
- rom_addr  out  8  address to the configuration ROM.
- rom_dout  in  16  ROM data: [15:8] register, [7:0] value. Registered ROM, valid 1 cycle after rom_addr changes.
- sccb_ready  in  1  SCCB master idle and able to accept a command.
- sccb_start  out  1  single-cycle command strobe.
- sccb_id  out  8  device address, constant DEV_ID.
- sccb_reg  out  8  register address for the current write.
- sccb_val  out  8  register value for the current write.
- sccb_done  in  1  single-cycle pulse at end of a transaction.
- sccb_nack  in  1  sampled only when sccb_done=1; 1 = transaction failed.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- done  out  1  level; high in DONE.
- error  out  1  level; high in ERROR.
- fail_addr  out  8  ROM address of the aborted entry; valid in ERROR.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0: rom_addr, sccb_start, sccb_reg, sccb_val, busy, done, error, fail_addr, retry counter and delay counter. sccb_id=DEV_ID at all times.
- DELAY_CYCLES = CLK_HZ/1000*DELAY_MS, computed at elaboration. The delay counter is wide enough to hold it (≥32 bits allowed).
- States:
  - IDLE: on start -> rom_addr=0, retry=0, go FETCH.
  - FETCH: one wait cycle for ROM latency -> DECODE.
  - DECODE: inspect rom_dout.
    - 16'hFFFF -> DONE.
    - 16'hFFF0 -> load delay counter with DELAY_CYCLES-1 -> DELAY.
    - Otherwise -> latch sccb_reg=rom_dout[15:8], sccb_val=rom_dout[7:0] -> ISSUE.
  - ISSUE: wait for sccb_ready=1. In that cycle pulse sccb_start for exactly 1 cycle -> WAIT.
  - WAIT: ignore sccb_ready; wait for sccb_done.
    - sccb_nack=0 -> retry=0, rom_addr+1 -> FETCH.
    - sccb_nack=1 and retry<MAX_RETRY -> retry+1 -> ISSUE (same reg/val).
    - sccb_nack=1 and retry=MAX_RETRY -> fail_addr=rom_addr -> ERROR.
  - DELAY: decrement each cycle. At 0 -> rom_addr+1 -> FETCH. Total time in DELAY is exactly DELAY_CYCLES cycles.
  - DONE: done=1. start -> restart as in IDLE (done drops the next cycle).
  - ERROR: error=1, holds. start -> restart as in IDLE; error and fail_addr clear.
- start is ignored while busy=1. A restart mid-sequence is only possible via rst_n.
- rom_addr wrap: if rom_addr=8'hFF is written successfully, the next address would wrap. Instead go to DONE without wrapping; this is treated as the end of table.
- Latency per normal entry: FETCH(1) + DECODE(1) + ISSUE(≥1) + WAIT (until sccb_done) + 1.
- sccb_done arriving outside WAIT is ignored.
- Asserting rst_n low mid-transaction returns to IDLE immediately and drops sccb_start. The SCCB master is responsible for its own abort.
- sccb_reg/sccb_val hold their last value outside ISSUE/WAIT.

Test Plan:
- Sequence run:
  - Stimulus: ROM {0:1280, 1:FFF0, 2:1204, 3:FFFF}, DELAY_MS=1, CLK_HZ=1_000_000. Model SCCB master ACKs after 20 cycles. Pulse start.
  - Expect: writes (12,80) then (12,04). Exactly 1000 cycles in DELAY. done=1, busy=0, 2 sccb_start pulses total.
- NACK retry:
  - Stimulus: entry 0 = 11_80, first 2 attempts NACK, third ACKs.
  - Expect: 3 sccb_start pulses with reg 11, val 80. Then proceeds to the next entry. error=0.
- NACK abort:
  - Stimulus: entry 5 always NACKs, MAX_RETRY=3.
  - Expect: 4 pulses for entry 5. error=1, fail_addr=5, busy=0, no further sccb_start. A subsequent start restarts from addr 0.
- Ready stall:
  - Stimulus: hold sccb_ready=0 for 50 cycles in ISSUE.
  - Expect: no sccb_start until ready rises; then exactly one 1-cycle pulse.
- Reset mid-operation:
  - Stimulus: drop rst_n during WAIT.
  - Expect: all outputs 0 asynchronously. After release: IDLE, no activity until start.
- Start ignored:
  - Stimulus: pulse start while busy.
  - Expect: rom_addr sequence unchanged. Entry-0 write not repeated.
